// File: rtl/zbuffer_pixel_writer.sv
// Depth-tested pixel writer: read-compare-write against a depth BRAM with a 2-cycle read,
// forwarding of recent writes, full-buffer clear, and frame/clear completion pulses.
module zbuffer_pixel_writer #(
    parameter int                     FB_HRES     = 320,
    parameter int                     FB_VRES     = 180,
    parameter int                     Z_WIDTH     = 20,
    parameter int                     COLOR_WIDTH = 16,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
    localparam int                    ADDR_W      = $clog2(FB_HRES * FB_VRES)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [ADDR_W-1:0]      addr_in,
    input  logic [Z_WIDTH-1:0]     z_in,
    input  logic [COLOR_WIDTH-1:0] color_in,
    input  logic                   last_pixel_in,
    input  logic                   clear_in,
    output logic [ADDR_W-1:0]      depth_raddr_out,
    input  logic [Z_WIDTH-1:0]     depth_rdata_in,
    output logic                   depth_we_out,
    output logic [ADDR_W-1:0]      depth_waddr_out,
    output logic [Z_WIDTH-1:0]     depth_wdata_out,
    output logic                   fb_we_out,
    output logic [ADDR_W-1:0]      fb_addr_out,
    output logic [COLOR_WIDTH-1:0] fb_data_out,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic                   clear_done_out
);
    localparam int                NPIX      = FB_HRES * FB_VRES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam int                HIST      = 3;

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic                   s1_v_q, s2_v_q;
    logic [ADDR_W-1:0]      s1_addr_q, s2_addr_q;
    logic [Z_WIDTH-1:0]     s1_z_q, s2_z_q;
    logic [COLOR_WIDTH-1:0] s1_color_q, s2_color_q;
    logic                   s1_last_q, s2_last_q;

    // Older write history: [0] issued one cycle ago, [1] two cycles ago.
    // The youngest entry is the live write register itself.
    logic                   hv_q [HIST-1];
    logic [ADDR_W-1:0]      ha_q [HIST-1];
    logic [Z_WIDTH-1:0]     hz_q [HIST-1];

    logic                   dwe_q, dwe_d;
    logic [ADDR_W-1:0]      dwaddr_q, dwaddr_d;
    logic [Z_WIDTH-1:0]     dwdata_q, dwdata_d;
    logic                   fbwe_q, fbwe_d;
    logic [ADDR_W-1:0]      fbaddr_q, fbaddr_d;
    logic [COLOR_WIDTH-1:0] fbdata_q, fbdata_d;
    logic                   busy_q, busy_d;
    logic                   fdone_q, fdone_d;
    logic                   cdone_q, cdone_d;

    logic               accept;
    logic [Z_WIDTH-1:0] eff_z;
    logic               win;

    // A clear request blocks the handshake in the same cycle, so clear wins over valid.
    assign ready_out       = (state_q == ST_RUN) && !clear_in && !rst_in;
    assign accept          = valid_in && ready_out;
    assign depth_raddr_out = addr_in;

    always_comb begin
        eff_z = depth_rdata_in;
        for (int i = HIST - 2; i >= 0; i--) begin
            if (hv_q[i] && (ha_q[i] == s2_addr_q)) eff_z = hz_q[i];
        end
        if (dwe_q && (dwaddr_q == s2_addr_q)) eff_z = dwdata_q;
    end

    assign win = s2_z_q < eff_z;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dwe_d    = 1'b0;
        dwaddr_d = '0;
        dwdata_d = '0;
        fbwe_d   = 1'b0;
        fbaddr_d = '0;
        fbdata_d = '0;
        cdone_d  = 1'b0;
        fdone_d  = s2_v_q && s2_last_q;
        case (state_q)
            ST_CLEAR: begin
                dwe_d    = 1'b1;
                dwaddr_d = cnt_q;
                dwdata_d = '1;
                fbwe_d   = 1'b1;
                fbaddr_d = cnt_q;
                fbdata_d = CLEAR_COLOR;
                if (cnt_q == LAST_ADDR) begin
                    cdone_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_in) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_v_q && !s2_v_q) state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
        if ((state_q != ST_CLEAR) && s2_v_q && win) begin
            dwe_d    = 1'b1;
            dwaddr_d = s2_addr_q;
            dwdata_d = s2_z_q;
            fbwe_d   = 1'b1;
            fbaddr_d = s2_addr_q;
            fbdata_d = s2_color_q;
        end
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            s1_z_q     <= '0;
            s2_z_q     <= '0;
            s1_color_q <= '0;
            s2_color_q <= '0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            for (int i = 0; i < HIST - 1; i++) begin
                hv_q[i] <= 1'b0;
                ha_q[i] <= '0;
                hz_q[i] <= '0;
            end
            dwe_q    <= 1'b0;
            dwaddr_q <= '0;
            dwdata_q <= '0;
            fbwe_q   <= 1'b0;
            fbaddr_q <= '0;
            fbdata_q <= '0;
            busy_q   <= 1'b0;
            fdone_q  <= 1'b0;
            cdone_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_v_q     <= accept;
            s2_v_q     <= s1_v_q;
            s1_addr_q  <= addr_in;
            s2_addr_q  <= s1_addr_q;
            s1_z_q     <= z_in;
            s2_z_q     <= s1_z_q;
            s1_color_q <= color_in;
            s2_color_q <= s1_color_q;
            s1_last_q  <= last_pixel_in;
            s2_last_q  <= s1_last_q;
            hv_q[0]    <= dwe_q;
            ha_q[0]    <= dwaddr_q;
            hz_q[0]    <= dwdata_q;
            for (int i = 1; i < HIST - 1; i++) begin
                hv_q[i] <= hv_q[i-1];
                ha_q[i] <= ha_q[i-1];
                hz_q[i] <= hz_q[i-1];
            end
            dwe_q    <= dwe_d;
            dwaddr_q <= dwaddr_d;
            dwdata_q <= dwdata_d;
            fbwe_q   <= fbwe_d;
            fbaddr_q <= fbaddr_d;
            fbdata_q <= fbdata_d;
            busy_q   <= busy_d;
            fdone_q  <= fdone_d;
            cdone_q  <= cdone_d;
        end
    end

    assign depth_we_out    = dwe_q;
    assign depth_waddr_out = dwaddr_q;
    assign depth_wdata_out = dwdata_q;
    assign fb_we_out       = fbwe_q;
    assign fb_addr_out     = fbaddr_q;
    assign fb_data_out     = fbdata_q;
    assign busy_out        = busy_q;
    assign frame_done_out  = fdone_q;
    assign clear_done_out  = cdone_q;

endmodule

// File: tb/tb_zbuffer_pixel_writer.sv
// Bench for zbuffer_pixel_writer: depth BRAM model plus an in-order depth-array reference,
// run on a reduced 48x32 framebuffer so full clears stay short.
module tb_zbuffer_pixel_writer;
    localparam int H  = 48;
    localparam int V  = 32;
    localparam int N  = H * V;
    localparam int AW = $clog2(N);
    localparam int ZW = 20;
    localparam int CW = 16;
    localparam logic [ZW-1:0] ZMAX = '1;
    localparam logic [CW-1:0] CCLR = 16'h0000;

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [AW-1:0] addr_in = '0;
    logic [ZW-1:0] z_in = '0;
    logic [CW-1:0] color_in = '0;
    logic          last_pixel_in = 1'b0;
    logic          clear_in = 1'b0;
    logic [AW-1:0] depth_raddr_out;
    logic [ZW-1:0] depth_rdata;
    logic          depth_we_out;
    logic [AW-1:0] depth_waddr_out;
    logic [ZW-1:0] depth_wdata_out;
    logic          fb_we_out;
    logic [AW-1:0] fb_addr_out;
    logic [CW-1:0] fb_data_out;
    logic          busy_out;
    logic          frame_done_out;
    logic          clear_done_out;

    zbuffer_pixel_writer #(.FB_HRES(H), .FB_VRES(V), .Z_WIDTH(ZW), .COLOR_WIDTH(CW), .CLEAR_COLOR(CCLR)) dut (
        .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
        .addr_in(addr_in), .z_in(z_in), .color_in(color_in), .last_pixel_in(last_pixel_in),
        .clear_in(clear_in), .depth_raddr_out(depth_raddr_out), .depth_rdata_in(depth_rdata),
        .depth_we_out(depth_we_out), .depth_waddr_out(depth_waddr_out), .depth_wdata_out(depth_wdata_out),
        .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out),
        .busy_out(busy_out), .frame_done_out(frame_done_out), .clear_done_out(clear_done_out)
    );

    always #5 clk = ~clk;

    // Depth BRAM: two registered read stages; a write is not seen by a read in the same cycle.
    logic [ZW-1:0] mem [2**AW];
    logic [ZW-1:0] rd1;
    always @(posedge clk) begin
        rd1         <= mem[depth_raddr_out];
        depth_rdata <= rd1;
        if (depth_we_out) mem[depth_waddr_out] <= depth_wdata_out;
    end

    typedef struct {
        int            due;
        logic          win;
        logic [AW-1:0] addr;
        logic [ZW-1:0] z;
        logic [CW-1:0] color;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [ZW-1:0] ref_depth [2**AW];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    logic          last_ready;

    function automatic void model_clear();
        for (int i = 0; i < 2**AW; i++) ref_depth[i] = ZMAX;
    endfunction

    // Drives one cycle; accepted pixels are resolved against the reference in acceptance order.
    task automatic tick(input logic v, input logic [AW-1:0] a, input logic [ZW-1:0] z,
                        input logic [CW-1:0] c, input logic l, input logic clr);
        exp_t e;
        valid_in = v; addr_in = a; z_in = z; color_in = c; last_pixel_in = l; clear_in = clr;
        #4;
        last_ready = ready_out;
        if (v && ready_out) begin
            e.due = cyc + 3; e.win = (z < ref_depth[a]); e.addr = a; e.z = z; e.color = c; e.last = l;
            if (e.win) ref_depth[a] = z;
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        valid_in = 1'b0; clear_in = 1'b0; last_pixel_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(0, '0, '0, '0, 0, 0);
            vectors++;
            if ({ready_out, depth_we_out, fb_we_out, busy_out, frame_done_out, clear_done_out} !== 6'b0 ||
                depth_waddr_out !== '0 || depth_wdata_out !== '0 || fb_addr_out !== '0 || fb_data_out !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d rdy=%b dwe=%b fwe=%b busy=%b fd=%b cd=%b, required all 0",
                         cyc, ready_out, depth_we_out, fb_we_out, busy_out, frame_done_out, clear_done_out);
            end
        end
        rst_in = 1'b0;
        tick(0, '0, '0, '0, 0, 0);
        for (int k = 0; k < N; k++) begin
            if (k > 0) tick(0, '0, '0, '0, 0, 0);
            vectors++;
            if (depth_we_out !== 1'b1 || fb_we_out !== 1'b1 || depth_waddr_out !== AW'(k) ||
                fb_addr_out !== AW'(k) || depth_wdata_out !== ZMAX || fb_data_out !== CCLR ||
                clear_done_out !== (k == N - 1) || (k < N - 1 && (busy_out !== 1'b1 || ready_out !== 1'b0))) begin
                miscompares++;
                $display("FAIL reset_clear k=%0d got we=%b addr=%0d z=%h c=%h cd=%b busy=%b rdy=%b",
                         k, depth_we_out, depth_waddr_out, depth_wdata_out, fb_data_out, clear_done_out, busy_out, ready_out);
            end
        end
        tick(0, '0, '0, '0, 0, 0);
        vectors++;
        if (ready_out !== 1'b1 || busy_out !== 1'b0 || clear_done_out !== 1'b0 || depth_we_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_run_entry got rdy=%b busy=%b cd=%b we=%b, required 1 0 0 0",
                     ready_out, busy_out, clear_done_out, depth_we_out);
        end
        model_clear();
    endtask

    task automatic test_single_pixel();
        tick(1, AW'(100), 20'd500, 16'hF00F, 0, 0);
        vectors++;
        if (last_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready got %b required 1", last_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) tick(0, '0, '0, '0, 0, 0);
            vectors++;
            if (k < 3 && (depth_we_out !== 1'b0 || fb_we_out !== 1'b0)) begin
                miscompares++;
                $display("FAIL single_early t+%0d got we=%b/%b required 0", k, depth_we_out, fb_we_out);
            end
            if (k == 3 && (depth_we_out !== 1'b1 || fb_we_out !== 1'b1 || depth_waddr_out !== AW'(100) ||
                           fb_addr_out !== AW'(100) || depth_wdata_out !== 20'd500 || fb_data_out !== 16'hF00F)) begin
                miscompares++;
                $display("FAIL single_write got we=%b addr=%0d z=%0d c=%h required we=1 addr=100 z=500 c=f00f",
                         depth_we_out, depth_waddr_out, depth_wdata_out, fb_data_out);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_forwarding();
        logic [ZW-1:0] zs [4];
        logic [ZW-1:0] written[$];
        logic [AW-1:0] a;
        exp_t e;
        logic ew, ef;
        int   span;
        zs[0] = 20'd300; zs[1] = 20'd200; zs[2] = 20'd250; zs[3] = 20'd200;
        for (int g = 0; g < 4; g++) begin
            a = AW'(7 + 10 * g);
            written.delete();
            span = g + 1;
            for (int i = 0; i < 4 * span + 4; i++) begin
                if ((i % span) == 0 && (i / span) < 4) tick(1, a, zs[i / span], CW'(16'hA000 + i), 0, 0);
                else tick(0, '0, '0, '0, 0, 0);
                ew = 1'b0; ef = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin e = exp_q.pop_front(); ew = e.win; ef = e.last; end
                vectors++;
                if (depth_we_out !== ew || fb_we_out !== ew || frame_done_out !== ef ||
                    (ew && (depth_waddr_out !== e.addr || fb_addr_out !== e.addr ||
                            depth_wdata_out !== e.z || fb_data_out !== e.color))) begin
                    miscompares++;
                    $display("FAIL fwd_gap%0d cyc=%0d got we=%b fd=%b a=%0d z=%0d c=%h want we=%b fd=%b a=%0d z=%0d c=%h",
                             g, cyc, depth_we_out, frame_done_out, depth_waddr_out, depth_wdata_out, fb_data_out,
                             ew, ef, e.addr, e.z, e.color);
                end
                if (depth_we_out && depth_waddr_out == a) written.push_back(depth_wdata_out);
            end
            vectors++;
            if (written.size() != 2 || written[0] != 20'd300 || written[1] != 20'd200) begin
                miscompares++;
                $display("FAIL fwd_depths gap=%0d got %0d writes first=%0d second=%0d, required 2 writes 300 then 200",
                         g, written.size(), (written.size() > 0) ? written[0] : '0, (written.size() > 1) ? written[1] : '0);
            end
        end
    endtask

    task automatic test_equal_last();
        tick(1, AW'(500), ZMAX, 16'h1234, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick(0, '0, '0, '0, 0, 0);
            vectors++;
            if (depth_we_out !== 1'b0 || fb_we_out !== 1'b0 || frame_done_out !== (k == 3)) begin
                miscompares++;
                $display("FAIL equal_last t+%0d got we=%b fd=%b required we=0 fd=%b",
                         k, depth_we_out, frame_done_out, (k == 3));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_clear_drain();
        exp_t e;
        logic ew, ef;
        int   waited;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) tick(1, AW'(200), 20'd10, 16'h00AA, 0, 0);
            else if (i == 1) tick(1, AW'(201), 20'd11, 16'h00BB, 1, 0);
            else if (i == 2) tick(1, AW'(202), 20'd12, 16'h00CC, 0, 1);
            else tick(0, '0, '0, '0, 0, 0);
            if (i == 2) begin
                vectors++;
                if (last_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clear_ready got %b required 0", last_ready);
                end
            end
            ew = 1'b0; ef = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin e = exp_q.pop_front(); ew = e.win; ef = e.last; end
            vectors++;
            if (depth_we_out !== ew || fb_we_out !== ew || frame_done_out !== ef ||
                (ew && (depth_waddr_out !== e.addr || depth_wdata_out !== e.z || fb_data_out !== e.color)) ||
                (i >= 2 && busy_out !== 1'b1)) begin
                miscompares++;
                $display("FAIL drain cyc=%0d got we=%b fd=%b a=%0d z=%0d busy=%b want we=%b fd=%b a=%0d z=%0d busy=%b",
                         cyc, depth_we_out, frame_done_out, depth_waddr_out, depth_wdata_out, busy_out,
                         ew, ef, e.addr, e.z, (i >= 2));
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_pending got %0d unissued required 0", exp_q.size());
        end
        waited = 0;
        while (!depth_we_out && waited < 3) begin
            tick(0, '0, '0, '0, 0, 0);
            waited++;
        end
        for (int k = 0; k < N; k++) begin
            if (k > 0) tick(0, '0, '0, '0, 0, 0);
            vectors++;
            if (depth_we_out !== 1'b1 || depth_waddr_out !== AW'(k) || fb_addr_out !== AW'(k) ||
                depth_wdata_out !== ZMAX || fb_data_out !== CCLR || clear_done_out !== (k == N - 1)) begin
                miscompares++;
                $display("FAIL drain_clear k=%0d got we=%b addr=%0d z=%h c=%h cd=%b",
                         k, depth_we_out, depth_waddr_out, depth_wdata_out, fb_data_out, clear_done_out);
                if (k == 0) break;
            end
        end
        model_clear();
        tick(0, '0, '0, '0, 0, 0);
        vectors++;
        if (ready_out !== 1'b1 || clear_done_out !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_run_entry got rdy=%b cd=%b required 1 0", ready_out, clear_done_out);
        end
    endtask

    task automatic test_random_stream();
        exp_t          e;
        logic          ew, ef, v, l;
        logic [AW-1:0] a;
        logic [ZW-1:0] z;
        for (int i = 0; i < 404; i++) begin
            v = (i < 400) && ($urandom_range(3) != 0);
            a = ($urandom_range(1) != 0) ? AW'($urandom_range(15)) : AW'($urandom_range(N - 1));
            z = ZW'($urandom);
            if ($urandom_range(7) == 0) z = ref_depth[a];
            l = ($urandom_range(15) == 0);
            tick(v, a, z, CW'($urandom), l, 0);
            ew = 1'b0; ef = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin e = exp_q.pop_front(); ew = e.win; ef = e.last; end
            vectors++;
            if (depth_we_out !== ew || fb_we_out !== ew || frame_done_out !== ef ||
                (ew && (depth_waddr_out !== e.addr || fb_addr_out !== e.addr ||
                        depth_wdata_out !== e.z || fb_data_out !== e.color))) begin
                miscompares++;
                $display("FAIL random cyc=%0d got we=%b fd=%b a=%0d z=%h c=%h want we=%b fd=%b a=%0d z=%h c=%h",
                         cyc, depth_we_out, frame_done_out, depth_waddr_out, depth_wdata_out, fb_data_out,
                         ew, ef, e.addr, e.z, e.color);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int reached;
        tick(1, AW'(300), 20'd5, 16'h5555, 1, 0);
        tick(1, AW'(301), 20'd6, 16'h6666, 0, 0);
        for (int pass = 0; pass < 2; pass++) begin
            rst_in = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick(0, '0, '0, '0, 0, 0);
                vectors++;
                if ({ready_out, depth_we_out, fb_we_out, busy_out, frame_done_out, clear_done_out} !== 6'b0 ||
                    depth_waddr_out !== '0 || depth_wdata_out !== '0) begin
                    miscompares++;
                    $display("FAIL rst%0d_outputs k=%0d rdy=%b we=%b busy=%b fd=%b cd=%b addr=%0d, required all 0",
                             pass, k, ready_out, depth_we_out, busy_out, frame_done_out, clear_done_out, depth_waddr_out);
                end
            end
            exp_q.delete();
            rst_in = 1'b0;
            tick(0, '0, '0, '0, 0, 0);
            reached = 0;
            for (int k = 0; k < N; k++) begin
                if (k > 0) tick(0, '0, '0, '0, 0, 0);
                vectors++;
                if (depth_we_out !== 1'b1 || depth_waddr_out !== AW'(k) || depth_wdata_out !== ZMAX ||
                    fb_data_out !== CCLR || frame_done_out !== 1'b0 || clear_done_out !== (k == N - 1)) begin
                    miscompares++;
                    $display("FAIL rst%0d_clear k=%0d got we=%b addr=%0d z=%h c=%h fd=%b cd=%b",
                             pass, k, depth_we_out, depth_waddr_out, depth_wdata_out, fb_data_out,
                             frame_done_out, clear_done_out);
                    break;
                end
                reached = k;
                if (pass == 0 && k == 1000) break;
            end
            vectors++;
            if (reached != ((pass == 0) ? 1000 : N - 1)) begin
                miscompares++;
                $display("FAIL rst%0d_progress got k=%0d required %0d", pass, reached, (pass == 0) ? 1000 : N - 1);
            end
        end
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_single_pixel();
        test_forwarding();
        test_equal_last();
        test_clear_drain();
        test_random_stream();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
